// File: rtl/opsum_writeback_pkg.sv
// Shared types and constants for the opsum writeback path.
// Holds the pass FSM encoding and the staging FIFO depth.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

package opsum_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/opsum_fifo.sv
// Small synchronous FIFO staging opsums toward the GLB.
// Push while full and pop while empty are ignored.
module opsum_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = wdata;
      wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/opsum_writeback.sv
// Collects a pass of opsums from the PE array and writes them
// to consecutive GLB addresses, with optional ReLU at accept.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module opsum_writeback
  import opsum_writeback_pkg::*;
#(
  parameter int DATA_SIZE = `DATA_BITS,
  parameter int ADDR_BITS = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [CNT_BITS-1:0]  opsum_count,
  input  logic                 relu_en,
  input  logic                 opsum_valid,
  output logic                 opsum_ready,
  input  logic [DATA_SIZE-1:0] opsum_data,
  output logic                 glb_we,
  output logic [ADDR_BITS-1:0] glb_addr,
  output logic [DATA_SIZE-1:0] glb_wdata,
  input  logic                 glb_grant,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  rem_q, rem_d;
  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic                 relu_q, relu_d;

  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] push_data;
  logic [DATA_SIZE-1:0] head;
  logic [FIFO_CW-1:0]   fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 drain_empty;

  assign opsum_ready = (state_q == COLLECT) && !fifo_full
                       && (rem_q != '0);
  assign push = opsum_valid && opsum_ready;
  assign push_data = (relu_q && opsum_data[DATA_SIZE-1])
                     ? '0 : opsum_data;

  assign glb_we    = !fifo_empty;
  assign glb_wdata = fifo_empty ? '0 : head;
  assign glb_addr  = wptr_q;
  assign pop       = glb_we && glb_grant;

  // True when the FIFO is, or is about to become, empty.
  assign drain_empty = fifo_empty
                       || (pop && fifo_cnt == FIFO_CW'(1));

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  opsum_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wptr_d  = wptr_q;
    relu_d  = relu_q;
    if (pop) begin
      wptr_d = wptr_q + ADDR_BITS'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (opsum_count != '0) begin
            rem_d   = opsum_count;
            wptr_d  = base_addr;
            relu_d  = relu_en;
            state_d = COLLECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      COLLECT: begin
        if (push) begin
          rem_d = rem_q - CNT_BITS'(1);
          if (rem_q == CNT_BITS'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wptr_q  <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wptr_q  <= wptr_d;
      relu_q  <= relu_d;
    end
  end

endmodule

// File: tb/tb_opsum_writeback.sv
// Directed bench for opsum_writeback with a write scoreboard.
// Expected GLB writes are queued at accept and checked on write.
module tb_opsum_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] opsum_count = '0;
  logic        relu_en = 1'b0;
  logic        opsum_valid = 1'b0;
  logic        opsum_ready;
  logic [15:0] opsum_data = '0;
  logic        glb_we;
  logic [15:0] glb_addr;
  logic [15:0] glb_wdata;
  logic        glb_grant = 1'b0;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] exp_addr = '0;
  logic        exp_relu = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_wr = 0;
  int          done_cnt = 0;

  opsum_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .opsum_count (opsum_count),
    .relu_en     (relu_en),
    .opsum_valid (opsum_valid),
    .opsum_ready (opsum_ready),
    .opsum_data  (opsum_data),
    .glb_we      (glb_we),
    .glb_addr    (glb_addr),
    .glb_wdata   (glb_wdata),
    .glb_grant   (glb_grant),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && glb_we && glb_grant) begin
      n_wr++;
      if (sb.size() == 0) begin
        chk("spurious_write", 32'(glb_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(glb_addr), 32'(e.addr));
        chk("wr_data", 32'(glb_wdata), 32'(e.data));
      end
    end
  end

  task automatic do_start(input logic [15:0] b, input logic [15:0] c,
                          input logic r);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = b;
    opsum_count = c;
    relu_en = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (c != 0) begin
      exp_addr = b;
      exp_relu = r;
    end
  endtask

  task automatic push_exp(input logic [15:0] d);
    exp_t x;
    x.addr = exp_addr;
    x.data = (exp_relu && d[15]) ? 16'h0 : d;
    sb.push_back(x);
    exp_addr = exp_addr + 16'd1;
  endtask

  task automatic send(input logic [15:0] d);
    logic got;
    got = 1'b0;
    opsum_valid = 1'b1;
    opsum_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (opsum_ready) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    opsum_valid = 1'b0;
    if (got) push_exp(d);
    else chk("send_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    int   d0;
    seen = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(opsum_ready), 32'd0);
    chk({tag, "_we"}, 32'(glb_we), 32'd0);
    chk({tag, "_addr"}, 32'(glb_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(glb_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  logic [15:0] bp [5];
  int          acc;
  int          k;
  int          w0;
  logic        a;

  initial begin
    bp[0] = 16'd100;
    bp[1] = 16'd200;
    bp[2] = 16'd300;
    bp[3] = 16'd400;
    bp[4] = 16'd500;

    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // basic pass
    glb_grant = 1'b1;
    w0 = n_wr;
    do_start(16'h0100, 16'd4, 1'b0);
    chk("basic_busy", 32'(busy), 32'd1);
    send(16'd5);
    chk("basic_latency_we", 32'(glb_we), 32'd1);
    chk("basic_latency_data", 32'(glb_wdata), 32'd5);
    send(-16'sd3);
    send(16'd7);
    send(16'd9);
    wait_done("basic");
    chk("basic_nwr", 32'(n_wr - w0), 32'd4);

    // relu
    do_start(16'h0200, 16'd2, 1'b1);
    send(-16'sd3);
    send(16'd8);
    wait_done("relu");

    // backpressure
    glb_grant = 1'b0;
    w0 = n_wr;
    do_start(16'h0300, 16'd5, 1'b0);
    acc = 0;
    k = 0;
    opsum_valid = 1'b1;
    opsum_data = bp[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a = opsum_ready;
      @(posedge clk);
      #1;
      if (a) begin
        push_exp(bp[k]);
        acc++;
        k++;
        opsum_data = bp[k];
      end
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_ready_low", 32'(opsum_ready), 32'd0);
    chk("bp_we_hold", 32'(glb_we), 32'd1);
    chk("bp_wdata_hold", 32'(glb_wdata), 32'(bp[0]));
    chk("bp_addr_hold", 32'(glb_addr), 32'h0300);
    glb_grant = 1'b1;
    for (int j = 2; j < 5; j++) send(bp[j]);
    wait_done("bp");
    chk("bp_nwr", 32'(n_wr - w0), 32'd5);

    // address wrap
    do_start(16'hFFFE, 16'd3, 1'b0);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    wait_done("wrap");
    chk("wrap_ptr", 32'(glb_addr), 32'h0001);

    // zero count
    w0 = n_wr;
    do_start(16'h0AAA, 16'd0, 1'b0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_we", 32'(glb_we), 32'd0);
    @(posedge clk);
    #1;
    chk("zero_done_drop", 32'(done), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_nwr", 32'(n_wr - w0), 32'd0);

    // reset mid-pass
    glb_grant = 1'b0;
    w0 = n_wr;
    do_start(16'h0400, 16'd4, 1'b0);
    send(16'd11);
    send(16'd22);
    glb_grant = 1'b1;
    repeat (2) @(posedge clk);
    #1 glb_grant = 1'b0;
    chk("mid_nwr", 32'(n_wr - w0), 32'd2);
    chk("mid_we_idle", 32'(glb_we), 32'd0);
    send(16'd33);
    chk("mid_we_pending", 32'(glb_we), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    sb.delete();
    glb_grant = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("mid_rst_hold");
    rst = 1'b0;
    w0 = n_wr;
    do_start(16'h0500, 16'd1, 1'b0);
    send(16'd42);
    wait_done("post_rst");
    chk("post_rst_nwr", 32'(n_wr - w0), 32'd1);

    // ignored start during collect
    do_start(16'h0600, 16'd3, 1'b0);
    send(16'd1);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 16'h0700;
    opsum_count = 16'd9;
    @(posedge clk);
    #1 start = 1'b0;
    send(16'd2);
    send(16'd3);
    wait_done("ign");
    chk("ign_ptr", 32'(glb_addr), 32'h0603);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
